// File: rtl/apb_pkg.sv
// Shared definitions for the round-robin APB master: bus widths, requester count, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package apb_pkg;

   localparam int APB_AW = 8;
   localparam int APB_DW = 8;
   localparam int NREQ   = 4;
   localparam int IDX_W  = 2;

   // Kept as plain 2-bit constants so older code that compares raw state
   // values keeps working.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_SETUP   = 2'd1;
   localparam state_t ST_ACCESS  = 2'd2;
   localparam state_t ST_CAPTURE = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector over NREQ requesters; owns the rotating priority pointer.
// Latency: grant/index are combinational from req; the pointer updates on the clock after advance.
// Backpressure: none; the pointer only moves when advance is high and some requester is selected.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset (pointer returns to 0)
//   req     [NREQ]   request vector to choose from
//   advance          commit the current selection; pointer moves past the winner
//   grant   [NREQ]   one-hot winner, zero when req is zero
//   index   [IDX_W]  binary index of the winner
module rr_arbiter
   import apb_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   input  logic             advance,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] index
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] cand;
   logic             found;

   // Search starts at the pointer; 2-bit arithmetic gives the 3->0 wrap.
   always_comb begin
      index = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = ptr_q + IDX_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
      grant = found ? (NREQ'(1) << index) : '0;
      ptr_d = (advance && found) ? index + IDX_W'(1) : ptr_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/apb_rr_master.sv
// Shares one APB slave between NREQ requesters using round-robin arbitration.
// Latency: SETUP one cycle after grant, done/err one cycle after the last ACCESS (read with lag: in CAPTURE).
// Backpressure: slave stalls via pready; TIMEOUT stalled ACCESS cycles abort with err; requesters hold req until done/err.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   req/req_write                  per-requester request and direction (1 = write)
//   req_addr/req_wdata             packed 8-bit fields, requester k at [8k+7:8k]
//   done/err                       one-cycle completion / timeout pulse to the granted requester
//   rdata                          read data, valid with done of a read, held until the next read
//   psel/penable/pwrite/paddr/pwdata/prdata/pready   APB master side
module apb_rr_master #(
   parameter int NREQ      = 4,
   parameter int TIMEOUT   = 16,
   parameter int RDATA_LAG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_write,
   input  logic [8*NREQ-1:0] req_addr,
   input  logic [8*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]   done,
   output logic [NREQ-1:0]   err,
   output logic [7:0]        rdata,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [7:0]        paddr,
   output logic [7:0]        pwdata,
   input  logic [7:0]        prdata,
   input  logic              pready
);
   import apb_pkg::*;

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_t            state_q, state_d;
   logic              wr_q, wr_d;
   logic [APB_AW-1:0] addr_q, addr_d;
   logic [APB_DW-1:0] wdata_q, wdata_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [NREQ-1:0]   err_q, err_d;
   logic [APB_DW-1:0] rdata_q, rdata_d;

   logic [NREQ-1:0]   req_eff;
   logic [NREQ-1:0]   arb_grant;
   logic [IDX_W-1:0]  arb_index;
   logic              arb_advance;

   // A requester sees its done/err pulse in the IDLE cycle and may still hold
   // req during it; masking it here prevents an immediate duplicate grant.
   assign req_eff     = req & ~(done_q | err_q);
   assign arb_advance = (state_q == ST_IDLE);

   rr_arbiter u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_eff),
      .advance (arb_advance),
      .grant   (arb_grant),
      .index   (arb_index)
   );

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      gnt_d   = gnt_q;
      wait_d  = wait_q;
      done_d  = '0;
      err_d   = '0;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (|req_eff) begin
               gnt_d   = arb_grant;
               wr_d    = req_write[arb_index];
               addr_d  = req_addr[int'(arb_index)*APB_AW +: APB_AW];
               wdata_d = req_wdata[int'(arb_index)*APB_DW +: APB_DW];
               wait_d  = '0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready) begin
               // done is registered, so it shows up in IDLE for the direct
               // path and in CAPTURE for the lagged-read path.
               done_d = gnt_q;
               if (wr_q || RDATA_LAG == 0) begin
                  if (!wr_q) rdata_d = prdata;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_CAPTURE;
               end
            end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
               err_d   = gnt_q;
               state_d = ST_IDLE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_CAPTURE: begin
            rdata_d = prdata;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         gnt_q   <= '0;
         wait_q  <= '0;
         done_q  <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         gnt_q   <= gnt_d;
         wait_q  <= wait_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign penable = (state_q == ST_ACCESS);
   assign pwrite  = wr_q;
   assign paddr   = addr_q;
   assign pwdata  = wdata_q;
   assign done    = done_q;
   assign err     = err_q;
   // In CAPTURE the slave's data is passed straight through so it is valid
   // alongside done; it is also registered to hold until the next read.
   assign rdata   = (state_q == ST_CAPTURE) ? prdata : rdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
module tb_apb_rr_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [3:0]  req_write = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  done, err;
   logic [7:0]  rdata;
   logic        psel, penable, pwrite, pready;
   logic [7:0]  paddr, pwdata;
   logic [7:0]  prdata = '0;

   always #5 clk = ~clk;

   apb_rr_master #(.NREQ(4), .TIMEOUT(8), .RDATA_LAG(1)) dut (
      .clk(clk), .reset(reset), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .err(err),
      .rdata(rdata), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
   );

   // ---------------- APB slave model (registered read) ----------------
   logic [7:0] mem [256];
   logic       mem_ready = 1'b0;
   logic       force_nr = 1'b0;
   int         wait_n = 0;
   int         acc_cnt = 0;

   function automatic logic [7:0] swap(input logic [7:0] a);
      return {a[3:0], a[7:4]};
   endfunction

   assign pready = penable && !force_nr && (acc_cnt >= wait_n);

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= swap(8'(i));
         mem_ready <= 1'b1;
      end else if (psel && penable && pready) begin
         if (pwrite) mem[paddr] <= pwdata;
         else        prdata <= mem[paddr];
      end
      acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic       is_err;
      int         idx;
      logic [7:0] rd;
   } exp_t;
   exp_t sbq[$];

   int   n_cmp = 0;
   int   n_fail = 0;
   logic gap_chk = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
      end
   endtask

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic push(input logic e, input int k, input logic [7:0] rd);
      exp_t x;
      x.is_err = e; x.idx = k; x.rd = rd;
      sbq.push_back(x);
   endtask

   // Monitor: pops an expectation whenever the DUT pulses done or err.
   initial begin
      exp_t e;
      logic psel_prev;
      int   idle_run;
      psel_prev = 1'b0;
      idle_run  = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (done != 0 || err != 0) begin
               check("resp_onehot", 32'(($countones(done | err) == 1) && ((done & err) == 0)), 32'd1);
               if (sbq.size() == 0) begin
                  check("unexpected_resp", {24'd0, done, err}, 32'd0);
               end else begin
                  e = sbq.pop_front();
                  check("resp_kind_err", 32'(err != 0), 32'(e.is_err));
                  check("resp_idx", 32'(idx_of(done | err)), 32'(e.idx));
                  check("resp_rdata", 32'(rdata), 32'(e.rd));
               end
            end
            if (psel && !psel_prev && gap_chk) check("idle_gap", 32'(idle_run), 32'd1);
            idle_run  = psel ? 0 : idle_run + 1;
            psel_prev = psel;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      req = req & ~(done | err);
   endtask

   task automatic set_req(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d);
      req_write[k]        = wr;
      req_addr[8*k +: 8]  = a;
      req_wdata[8*k +: 8] = d;
      req[k]              = 1'b1;
   endtask

   task automatic drain(input string nm, input int budget);
      int n;
      n = 0;
      while ((req != 0 || psel) && n < budget) begin
         tick();
         n++;
      end
      check(nm, 32'(n < budget), 32'd1);
      tick();
      tick();
   endtask

   initial begin
      int cnt;

      repeat (3) tick();
      check("rst_psel_penable", {30'd0, psel, penable}, 32'd0);
      check("rst_apb_fields", {15'd0, pwrite, paddr, pwdata}, 32'd0);
      check("rst_resp", {16'd0, rdata, done, err}, 32'd0);
      reset = 1'b0;
      tick();

      // Read of 0xA5 straight after reset, slave inserts 2 wait states.
      wait_n = 2;
      push(1'b0, 1, 8'h5A);
      set_req(1, 1'b0, 8'hA5, 8'h00);
      drain("drain_rd_a5", 40);
      wait_n = 0;

      // Write 0x33 to 0x10 from requester 0; address changed during SETUP.
      push(1'b0, 0, 8'h5A);
      set_req(0, 1'b1, 8'h10, 8'h33);
      tick();
      check("wr_setup_ctl", {30'd0, psel, penable}, 32'b10);
      check("wr_setup_fields", {15'd0, pwrite, paddr, pwdata}, {15'd0, 1'b1, 8'h10, 8'h33});
      req_addr[7:0] = 8'h12;
      tick();
      check("wr_access_ctl", {30'd0, psel, penable}, 32'b11);
      check("wr_access_paddr", 32'(paddr), 32'h10);
      tick();
      check("wr_done_psel", 32'(psel), 32'd0);
      drain("drain_wr", 20);
      check("mem_10", 32'(mem[8'h10]), 32'h33);
      check("mem_12_untouched", 32'(mem[8'h12]), 32'h21);

      // Read back 0x10 via requester 1: CAPTURE cycle carries done and data.
      push(1'b0, 1, 8'h33);
      set_req(1, 1'b0, 8'h10, 8'h00);
      tick();
      tick();
      tick();
      check("cap_ctl", {30'd0, psel, penable}, 32'd0);
      check("cap_done", 32'(done), 32'b0010);
      check("cap_rdata", 32'(rdata), 32'h33);
      drain("drain_rd_10", 20);

      // Requester 3 write moves the pointer back to 0.
      push(1'b0, 3, 8'h33);
      set_req(3, 1'b1, 8'h30, 8'h99);
      drain("drain_wr3", 20);
      check("mem_30", 32'(mem[8'h30]), 32'h99);

      // Contention: all four held, expect 0,1,2,3 with one idle between.
      for (int k = 0; k < 4; k++) begin
         push(1'b0, k, 8'h33);
         set_req(k, 1'b1, 8'(8'h20 + k), 8'(8'h40 + k));
      end
      tick();
      tick();
      gap_chk = 1'b1;
      drain("drain_all4", 80);
      gap_chk = 1'b0;
      for (int k = 0; k < 4; k++) check("mem_contention", 32'(mem[8'(8'h20 + k)]), 32'(8'h40 + k));

      // 0101 with pointer at 0: expect 0 then 2.
      push(1'b0, 0, 8'h33);
      push(1'b0, 2, 8'h33);
      set_req(0, 1'b1, 8'h50, 8'h11);
      set_req(2, 1'b1, 8'h52, 8'h22);
      tick();
      tick();
      gap_chk = 1'b1;
      drain("drain_0101", 40);
      gap_chk = 1'b0;

      // Timeout: slave never ready; 8 ACCESS cycles then err[2], rdata kept.
      force_nr = 1'b1;
      push(1'b1, 2, 8'h33);
      set_req(2, 1'b0, 8'h40, 8'h00);
      cnt = 0;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (psel && penable) cnt++;
         if (req == 0 && !psel) break;
      end
      check("timeout_access_cycles", 32'(cnt), 32'd8);
      tick();
      tick();

      // Reset asserted during ACCESS of a stalled write from requester 1.
      set_req(1, 1'b1, 8'h60, 8'h66);
      tick();
      tick();
      check("pre_rst_access", {30'd0, psel, penable}, 32'b11);
      reset = 1'b1;
      #1;
      check("midrst_ctl", {29'd0, psel, penable, pwrite}, 32'd0);
      check("midrst_data", {8'd0, paddr, pwdata, rdata}, 32'd0);
      check("midrst_resp", {24'd0, done, err}, 32'd0);
      req = '0;
      tick();
      tick();
      reset = 1'b0;
      force_nr = 1'b0;
      tick();
      check("mem_60_aborted", 32'(mem[8'h60]), 32'h06);

      // Pointer restarts at 0: 1010 -> 1 then 3, then 0011 -> 0 then 1.
      push(1'b0, 1, 8'h00);
      push(1'b0, 3, 8'h00);
      set_req(1, 1'b1, 8'h61, 8'h71);
      set_req(3, 1'b1, 8'h63, 8'h73);
      drain("drain_1010", 40);
      push(1'b0, 0, 8'h00);
      push(1'b0, 1, 8'h00);
      set_req(0, 1'b1, 8'h64, 8'h74);
      set_req(1, 1'b1, 8'h65, 8'h75);
      drain("drain_0011", 40);
      check("mem_61", 32'(mem[8'h61]), 32'h71);
      check("mem_65", 32'(mem[8'h65]), 32'h75);

      repeat (3) tick();
      check("sb_empty", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/apb_rr_master.md
APB_RR_MASTER -- requirements
Module: apb_rr_master

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one APB slave (fixed 4 in this revision).
REQ-002 Parameter TIMEOUT, default 16, maximum ACCESS cycles waiting for pready before the transfer is aborted.
REQ-003 Parameter RDATA_LAG, default 1: 0 = sample prdata in the ACCESS cycle with pready; 1 = sample prdata one cycle later (registered-read slaves).
REQ-004 Clock clk, single rising-edge clock domain; reset reset, asynchronous, active-high.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 req  in  4  per-requester transfer request, held until done or err.
REQ-008 req_write  in  4  per-requester direction, 1 = write.
REQ-009 req_addr  in  32  packed 4x8 addresses, requester k at bits [8k+7:8k].
REQ-010 req_wdata  in  32  packed 4x8 write data, same packing.
REQ-011 done  out  4  one-cycle completion pulse to the granted requester.
REQ-012 err  out  4  one-cycle timeout pulse to the granted requester.
REQ-013 rdata  out  8  read data, valid in the done cycle of a read, held until the next read completes.
REQ-014 psel, penable, pwrite  out  1 each  APB control.
REQ-015 paddr, pwdata  out  8 each  APB address and write data.
REQ-016 prdata  in  8  APB read data; pready  in  1  APB ready.

Function
REQ-017 FSM states: IDLE, SETUP, ACCESS, CAPTURE; encoding is free.
REQ-018 IDLE: if any req bit is set, the arbiter SHALL select one requester, latch its write/addr/wdata, and move to SETUP; otherwise it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: search starts at pointer ptr and wraps 3->0; after a grant to k, ptr SHALL become (k+1) mod 4.
REQ-020 SETUP (exactly one cycle): psel=1 and penable=0; paddr, pwdata and pwrite SHALL be driven from the latched values; the FSM then moves to ACCESS.
REQ-021 ACCESS: psel=1 and penable=1; paddr, pwdata and pwrite SHALL stay stable until the state is left.
REQ-022 ACCESS with pready=1 SHALL complete the transfer:
  - write, or read with RDATA_LAG=0: done[k] pulses the next cycle, FSM returns to IDLE; for RDATA_LAG=0 reads, rdata is loaded from prdata in the pready cycle.
  - read with RDATA_LAG=1: FSM goes to CAPTURE.
REQ-023 CAPTURE: psel=0 and penable=0; rdata SHALL be loaded from prdata, done[k] SHALL pulse in the same cycle, and the FSM moves to IDLE.
REQ-024 A wait counter SHALL count ACCESS cycles with pready=0; on reaching TIMEOUT, the FSM SHALL drop psel/penable, pulse err[k], leave rdata unchanged, and return to IDLE.
REQ-025 At least one IDLE cycle (psel=0) SHALL separate consecutive transfers.
REQ-026 Deasserting req mid-transfer SHALL NOT abort the transfer; done/err is still pulsed.
REQ-027 Changing req_addr, req_wdata or req_write after the grant SHALL NOT affect the transfer in flight.
REQ-028 done and err SHALL be one-hot-or-zero and never asserted together.

Reset
REQ-029 While reset is high: state=IDLE, ptr=0, wait counter=0, and every output (psel, penable, pwrite, paddr, pwdata, rdata, done, err) SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL abort it immediately with no done/err pulse; the first grant after release SHALL use ptr=0.

Structure
REQ-031 Shared package apb_pkg SHALL hold the FSM state type, APB_AW=8, APB_DW=8, and NREQ=4.
REQ-032 Round-robin selection and ptr SHALL live in sub-module rr_arbiter (inputs req and advance; outputs one-hot grant and index); everything else stays in apb_rr_master.

Verification (bench instantiates apb_rr_master with apb_slave, pready model overridable)
REQ-033 Write: req[0], addr 0x10, data 0x33 -> psel rises 1 cycle after req, penable 1 cycle later, done[0] pulses 1 cycle after ACCESS, slave mem[0x10]=0x33.
REQ-034 Read: req[1] read of 0x10 after the write, RDATA_LAG=1 -> CAPTURE entered, rdata=0x33 with done[1]; read of 0xA5 directly after reset -> rdata=0x5A.
REQ-035 Contention: req=4'b1111 held -> grants in order 0,1,2,3 with one IDLE cycle between; then req=4'b0101 with ptr=0 -> order 0,2.
REQ-036 Timeout: pready forced 0, TIMEOUT=8 -> exactly 8 ACCESS cycles, err[2] pulse, no done, rdata unchanged.
REQ-037 Reset in ACCESS: reset pulsed -> all outputs 0 that cycle, no done/err; after release, req=4'b1000 is granted to 3 and then ptr=0.
REQ-038 Stability: req_addr changed during SETUP -> paddr unchanged until the transfer completes.
